// File: rtl/vga_fb_arbiter.sv
// Round-robin arbiter that merges several pixel-write streams into one registered frame-buffer port.
// A clear request takes over the port and sweeps every pixel of the frame with a single colour.
module vga_fb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 11,
    parameter int COLOR_W = 2,
    parameter int H_SIZE  = 1280,
    parameter int V_SIZE  = 1024
) (
    input  logic                       clk_i,
    input  logic                       arstn_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_x_i,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_y_i,
    input  logic [NUM_REQ*COLOR_W-1:0] req_color_i,
    input  logic                       clear_i,
    input  logic [COLOR_W-1:0]         clear_color_i,
    output logic                       busy_o,
    output logic                       we_o,
    output logic [ADDR_W-1:0]          addr_x_o,
    output logic [ADDR_W-1:0]          addr_y_o,
    output logic [COLOR_W-1:0]         color_o,
    output logic [NUM_REQ-1:0]         grant_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int XW    = $clog2(H_SIZE + 1);
    localparam int YW    = $clog2(V_SIZE + 1);

    typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [XW-1:0]      sweep_x_q, sweep_x_d;
    logic [YW-1:0]      sweep_y_q, sweep_y_d;
    logic [COLOR_W-1:0] clr_color_q, clr_color_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_x_q, addr_x_d;
    logic [ADDR_W-1:0]  addr_y_q, addr_y_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic               found;
    logic [PTR_W-1:0]   sel;
    logic [NUM_REQ-1:0] sel_oh;
    logic               accept;
    logic               sweep_last;
    logic [XW-1:0]      sweep_x_nxt;
    logic [YW-1:0]      sweep_y_nxt;

    // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                sel   = PTR_W'(idx);
            end
        end
    end

    assign sel_oh      = NUM_REQ'(1) << sel;
    assign accept      = (state_q == ARB) && !clear_i && found;
    assign req_ready_o = accept ? sel_oh : '0;

    // The sweep counters hold the position currently shown on the outputs.
    assign sweep_last  = (sweep_x_q == XW'(H_SIZE - 1)) && (sweep_y_q == YW'(V_SIZE - 1));
    assign sweep_x_nxt = (sweep_x_q == XW'(H_SIZE - 1)) ? '0 : sweep_x_q + XW'(1);
    assign sweep_y_nxt = (sweep_x_q == XW'(H_SIZE - 1)) ? sweep_y_q + YW'(1) : sweep_y_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (clear_i) state_d = CLEAR;
            CLEAR:   if (sweep_last) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        sweep_x_d   = sweep_x_q;
        sweep_y_d   = sweep_y_q;
        clr_color_d = clr_color_q;
        we_d        = 1'b0;
        grant_d     = '0;
        addr_x_d    = addr_x_q;
        addr_y_d    = addr_y_q;
        color_d     = color_q;
        case (state_q)
            ARB: begin
                if (clear_i) begin
                    sweep_x_d   = '0;
                    sweep_y_d   = '0;
                    clr_color_d = clear_color_i;
                    we_d        = 1'b1;
                    addr_x_d    = '0;
                    addr_y_d    = '0;
                    color_d     = clear_color_i;
                end else if (accept) begin
                    we_d     = 1'b1;
                    grant_d  = sel_oh;
                    addr_x_d = req_x_i[int'(sel)*ADDR_W +: ADDR_W];
                    addr_y_d = req_y_i[int'(sel)*ADDR_W +: ADDR_W];
                    color_d  = req_color_i[int'(sel)*COLOR_W +: COLOR_W];
                    ptr_d    = PTR_W'((int'(sel) + 1) % NUM_REQ);
                end
            end
            CLEAR: begin
                if (!sweep_last) begin
                    sweep_x_d = sweep_x_nxt;
                    sweep_y_d = sweep_y_nxt;
                    we_d      = 1'b1;
                    addr_x_d  = ADDR_W'(sweep_x_nxt);
                    addr_y_d  = ADDR_W'(sweep_y_nxt);
                    color_d   = clr_color_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ptr_q       <= '0;
            sweep_x_q   <= '0;
            sweep_y_q   <= '0;
            clr_color_q <= '0;
            we_q        <= 1'b0;
            addr_x_q    <= '0;
            addr_y_q    <= '0;
            color_q     <= '0;
            grant_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            sweep_x_q   <= sweep_x_d;
            sweep_y_q   <= sweep_y_d;
            clr_color_q <= clr_color_d;
            we_q        <= we_d;
            addr_x_q    <= addr_x_d;
            addr_y_q    <= addr_y_d;
            color_q     <= color_d;
            grant_q     <= grant_d;
        end
    end

    assign busy_o   = (state_q == CLEAR);
    assign we_o     = we_q;
    assign addr_x_o = addr_x_q;
    assign addr_y_o = addr_y_q;
    assign color_o  = color_q;
    assign grant_o  = grant_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter on a 4x3 frame with two requesters.
// A cycle model predicts ready and the registered write of each cycle; the prediction is checked one edge later.
module tb_vga_fb_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 11;
    localparam int COLOR_W = 2;
    localparam int H_SIZE  = 4;
    localparam int V_SIZE  = 3;

    logic                       clk = 1'b0;
    logic                       arstn;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*ADDR_W-1:0]  req_x;
    logic [NUM_REQ*ADDR_W-1:0]  req_y;
    logic [NUM_REQ*COLOR_W-1:0] req_color;
    logic                       clear;
    logic [COLOR_W-1:0]         clear_color;
    logic                       busy;
    logic                       we;
    logic [ADDR_W-1:0]          addr_x;
    logic [ADDR_W-1:0]          addr_y;
    logic [COLOR_W-1:0]         color;
    logic [NUM_REQ-1:0]         grant;

    vga_fb_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W),
        .H_SIZE(H_SIZE), .V_SIZE(V_SIZE)
    ) dut (
        .clk_i(clk), .arstn_i(arstn),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_x_i(req_x), .req_y_i(req_y), .req_color_i(req_color),
        .clear_i(clear), .clear_color_i(clear_color),
        .busy_o(busy), .we_o(we),
        .addr_x_o(addr_x), .addr_y_o(addr_y), .color_o(color),
        .grant_o(grant)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               we;
        logic               busy;
        logic [ADDR_W-1:0]  x;
        logic [ADDR_W-1:0]  y;
        logic [COLOR_W-1:0] c;
        logic [NUM_REQ-1:0] g;
    } exp_t;

    exp_t sb[$];

    int nchk = 0;
    int nerr = 0;

    int                 m_ptr;
    logic               m_busy;
    int                 m_cnt;
    logic [COLOR_W-1:0] m_col;
    logic [ADDR_W-1:0]  last_x, last_y;
    logic [COLOR_W-1:0] last_c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_busy = 1'b0;
        m_cnt  = 0;
        m_col  = '0;
        last_x = '0;
        last_y = '0;
        last_c = '0;
        sb.delete();
    endtask

    task automatic set_req(input int i, input int x, input int y, input int c);
        req_x[i*ADDR_W +: ADDR_W]      = ADDR_W'(x);
        req_y[i*ADDR_W +: ADDR_W]      = ADDR_W'(y);
        req_color[i*COLOR_W +: COLOR_W] = COLOR_W'(c);
    endtask

    // Predict this cycle, then check the registered result after the next rising edge.
    task automatic cycle();
        exp_t               e;
        exp_t               got;
        logic [NUM_REQ-1:0] er;
        int                 idx;
        @(negedge clk);
        er = '0;
        e  = '0;
        if (!m_busy) begin
            if (clear) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_col  = clear_color;
                e.we = 1'b1; e.busy = 1'b1; e.x = '0; e.y = '0; e.c = clear_color;
            end else if (req_valid != '0) begin
                idx = req_valid[m_ptr] ? m_ptr : (m_ptr + 1) % NUM_REQ;
                er[idx] = 1'b1;
                e.we = 1'b1;
                e.x  = req_x[idx*ADDR_W +: ADDR_W];
                e.y  = req_y[idx*ADDR_W +: ADDR_W];
                e.c  = req_color[idx*COLOR_W +: COLOR_W];
                e.g  = er;
                m_ptr = (idx + 1) % NUM_REQ;
            end
        end else begin
            m_cnt++;
            if (m_cnt == H_SIZE * V_SIZE) begin
                m_busy = 1'b0;
            end else begin
                e.we = 1'b1; e.busy = 1'b1;
                e.x  = ADDR_W'(m_cnt % H_SIZE);
                e.y  = ADDR_W'(m_cnt / H_SIZE);
                e.c  = m_col;
            end
        end
        if (!e.we) begin
            e.x = last_x; e.y = last_y; e.c = last_c;
        end
        last_x = e.x; last_y = e.y; last_c = e.c;
        chk("ready", 32'(req_ready), 32'(er));
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            chk("we",     32'(we),     32'(got.we));
            chk("busy",   32'(busy),   32'(got.busy));
            chk("grant",  32'(grant),  32'(got.g));
            chk("addr_x", 32'(addr_x), 32'(got.x));
            chk("addr_y", 32'(addr_y), 32'(got.y));
            chk("color",  32'(color),  32'(got.c));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_we"},    32'(we),     32'd0);
        chk({tag, "_busy"},  32'(busy),   32'd0);
        chk({tag, "_grant"}, 32'(grant),  32'd0);
        chk({tag, "_x"},     32'(addr_x), 32'd0);
        chk({tag, "_y"},     32'(addr_y), 32'd0);
        chk({tag, "_color"}, 32'(color),  32'd0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        #1;
        arstn     = 1'b0;
        req_valid = '0;
        clear     = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        #1;
        arstn = 1'b1;
        #0;
        chk("busy_after_release", 32'(busy), 32'd0);
    endtask

    initial begin
        arstn       = 1'b0;
        req_valid   = '0;
        req_x       = '0;
        req_y       = '0;
        req_color   = '0;
        clear       = 1'b0;
        clear_color = '0;
        model_reset();
        #12;
        check_zero_outputs("reset");
        arstn = 1'b1;

        // Single requester 0.
        set_req(0, 5, 7, 2);
        set_req(1, 9, 4, 1);
        req_valid = 2'b01;
        cycle();
        req_valid = 2'b00;
        cycle();

        // Fresh reset, then both requesters valid continuously.
        do_reset();
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            set_req(0, 10 + i, 20 + i, i % 4);
            set_req(1, 30 + i, 40 + i, (i + 1) % 4);
            cycle();
        end

        // Clear with colour 3 while both are valid.
        clear       = 1'b1;
        clear_color = 2'd3;
        cycle();
        clear       = 1'b0;
        clear_color = 2'd0;
        for (int i = 0; i < 14; i++) cycle();

        // Clear re-pulsed in the middle of a sweep is ignored.
        req_valid   = 2'b00;
        clear       = 1'b1;
        clear_color = 2'd1;
        cycle();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        clear       = 1'b1;
        clear_color = 2'd2;
        cycle();
        clear = 1'b0;
        for (int i = 0; i < 10; i++) cycle();

        // Idle for 10 cycles, then the round-robin pointer resumes where it was.
        for (int i = 0; i < 10; i++) cycle();
        set_req(0, 100, 200, 1);
        set_req(1, 300, 400, 3);
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) cycle();
        req_valid = 2'b00;

        // Reset while the fifth clear write is on the outputs.
        clear       = 1'b1;
        clear_color = 2'd2;
        cycle();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        do_reset();
        set_req(0, 2047, 1, 3);
        req_valid = 2'b11;
        cycle();
        req_valid = 2'b00;
        cycle();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
